hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the ID/EX stage register and its neighbours in the 5-stage RISC-V pipeline. It detects load-use hazards and inserts a bubble into ID/EX while freezing PC and IF/ID. It flushes IF/ID, ID/EX and EX/MEM when a branch taken in MEM is resolved, and freezes the whole pipeline while data memory is busy. It also keeps saturating performance counters and a sticky freeze-timeout flag.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the ID/EX hazard controller and the pipeline datapath.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IfIdRs1;
  logic [4:0]       IfIdRs2;
  logic             UsesRs1;
  logic             UsesRs2;
  logic             IdExMemRead;
  logic [4:0]       IdExRd;
  logic             BranchTaken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IfIdWrite;
  logic             IdExBubble;
  logic             IfIdFlush;
  logic             IdExFlush;
  logic             ExMemFlush;
  logic             PipeHold;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic [CNT_W-1:0] FreezeCount;
  logic             Timeout;

  modport slave (
    input  IfIdRs1, IfIdRs2, UsesRs1, UsesRs2, IdExMemRead, IdExRd, BranchTaken, MemBusy,
    output PCWrite, IfIdWrite, IdExBubble, IfIdFlush, IdExFlush, ExMemFlush, PipeHold,
           State, StallCount, FlushCount, FreezeCount, Timeout
  );

  modport master (
    output IfIdRs1, IfIdRs2, UsesRs1, UsesRs2, IdExMemRead, IdExRd, BranchTaken, MemBusy,
    input  PCWrite, IfIdWrite, IdExBubble, IfIdFlush, IdExFlush, ExMemFlush, PipeHold,
           State, StallCount, FlushCount, FreezeCount, Timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and memory-freeze sequencing for the ID/EX stage,
// with saturating event counters and a sticky freeze-timeout flag.
module hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FREEZE_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned FRZ_W = $clog2(FREEZE_MAX + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } action_t;

  action_t          state;
  action_t          action;
  logic             hazard;
  logic             pc_write;
  logic             ifid_write;
  logic             bubble;
  logic             flush;
  logic             hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic [FRZ_W-1:0] frz_run;
  logic             timeout;

  assign hazard = bus.IdExMemRead && (bus.IdExRd != 5'd0) &&
                  ((bus.UsesRs1 && (bus.IfIdRs1 == bus.IdExRd)) ||
                   (bus.UsesRs2 && (bus.IfIdRs2 == bus.IdExRd)));

  // Per-cycle action and the combinational pipeline controls, by fixed priority
  always_comb begin
    action     = RUN;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    hold       = 1'b0;
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end else if (bus.MemBusy) begin
      action     = FREEZE;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      hold       = 1'b1;
    end else if (bus.BranchTaken) begin
      action     = FLUSH;
      flush      = 1'b1;
    end else if (hazard) begin
      action     = STALL;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= action;
  end

  // Saturating event counters plus the consecutive-freeze watchdog
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
      frz_run    <= '0;
      timeout    <= 1'b0;
    end else begin
      if ((action == STALL) && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
      if ((action == FLUSH) && (flush_cnt != '1))   flush_cnt  <= flush_cnt + CNT_W'(1);
      if ((action == FREEZE) && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + CNT_W'(1);
      if (action == FREEZE) begin
        if (frz_run != FRZ_W'(FREEZE_MAX)) frz_run <= frz_run + FRZ_W'(1);
        if (frz_run >= FRZ_W'(FREEZE_MAX - 1)) timeout <= 1'b1;
      end else begin
        frz_run <= '0;
      end
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IfIdWrite   = ifid_write;
  assign bus.IdExBubble  = bubble;
  assign bus.IfIdFlush   = flush;
  assign bus.IdExFlush   = flush;
  assign bus.ExMemFlush  = flush;
  assign bus.PipeHold    = hold;
  assign bus.State       = state;
  assign bus.StallCount  = stall_cnt;
  assign bus.FlushCount  = flush_cnt;
  assign bus.FreezeCount = freeze_cnt;
  assign bus.Timeout     = timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences
// and random traffic against a spec-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FREEZE_MAX = 16;
  localparam int          CNT_SAT    = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_state, m_stall, m_flush, m_freeze, m_run, m_timeout;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       bt;
    logic       mb;
    logic [4:0] exp_ctl;   // {PCWrite, IfIdWrite, IdExBubble, flush, PipeHold}
    int         exp_state; // State after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr,
                       input logic [4:0] rd, input logic bt, input logic mb);
    reset           = rst;
    hif.IfIdRs1     = rs1;
    hif.IfIdRs2     = rs2;
    hif.UsesRs1     = u1;
    hif.UsesRs2     = u2;
    hif.IdExMemRead = mr;
    hif.IdExRd      = rd;
    hif.BranchTaken = bt;
    hif.MemBusy     = mb;
  endtask

  // Spec-level action: -1 reset, else 0 RUN 1 STALL 2 FLUSH 3 FREEZE
  function automatic int model_action();
    bit hz;
    if (!reset) return -1;
    if (hif.MemBusy) return 3;
    if (hif.BranchTaken) return 2;
    hz = hif.IdExMemRead && (hif.IdExRd != 0) &&
         ((hif.UsesRs1 && hif.IfIdRs1 == hif.IdExRd) || (hif.UsesRs2 && hif.IfIdRs2 == hif.IdExRd));
    return hz ? 1 : 0;
  endfunction

  function automatic logic [4:0] model_ctl(input int act);
    case (act)
      0:       return 5'b11000;
      1:       return 5'b00100;
      2:       return 5'b11010;
      3:       return 5'b00001;
      default: return 5'b00100;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : v;
  endfunction

  // One clock: check combinational controls, clock, advance model, check registers
  task automatic step();
    int         act;
    logic [4:0] exp;
    #2;
    act = model_action();
    exp = model_ctl(act);
    check("PCWrite",    int'(hif.PCWrite),    int'(exp[4]));
    check("IfIdWrite",  int'(hif.IfIdWrite),  int'(exp[3]));
    check("IdExBubble", int'(hif.IdExBubble), int'(exp[2]));
    check("IfIdFlush",  int'(hif.IfIdFlush),  int'(exp[1]));
    check("IdExFlush",  int'(hif.IdExFlush),  int'(exp[1]));
    check("ExMemFlush", int'(hif.ExMemFlush), int'(exp[1]));
    check("PipeHold",   int'(hif.PipeHold),   int'(exp[0]));
    @(posedge clk);
    #1;
    if (act < 0) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0; m_run = 0; m_timeout = 0;
    end else begin
      m_state = act;
      if (act == 1) m_stall  = sat_inc(m_stall);
      if (act == 2) m_flush  = sat_inc(m_flush);
      if (act == 3) begin
        m_freeze = sat_inc(m_freeze);
        m_run    = (m_run < FREEZE_MAX) ? m_run + 1 : m_run;
        if (m_run == FREEZE_MAX) m_timeout = 1;
      end else begin
        m_run = 0;
      end
    end
    check("State",       int'(hif.State),       m_state);
    check("StallCount",  int'(hif.StallCount),  m_stall);
    check("FlushCount",  int'(hif.FlushCount),  m_flush);
    check("FreezeCount", int'(hif.FreezeCount), m_freeze);
    check("Timeout",     int'(hif.Timeout),     m_timeout);
  endtask

  task automatic idle(input logic rst);
    drive(rst, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle(1'b0);
    step();
    idle(1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0; m_run = 0; m_timeout = 0;

    // rst rs1 rs2 u1 u2 mr rd bt mb exp_ctl exp_state
    vecs.push_back('{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'b00100, 0});
    vecs.push_back('{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'b00100, 0});
    vecs.push_back('{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'b00100, 0});
    vecs.push_back('{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00100, 1});
    vecs.push_back('{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'b11000, 0});
    vecs.push_back('{1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000, 0});
    vecs.push_back('{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'b11010, 2});
    vecs.push_back('{1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'b00100, 1});
    vecs.push_back('{1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 5'b11000, 0});
    vecs.push_back('{1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 5'b00001, 3});

    idle(1'b0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].mr, vecs[i].rd, vecs[i].bt, vecs[i].mb);
      #2;
      check($sformatf("vec%0d_ctl", i),
            int'({hif.PCWrite, hif.IfIdWrite, hif.IdExBubble, hif.IfIdFlush, hif.PipeHold}),
            int'(vecs[i].exp_ctl));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", i), int'(hif.State), vecs[i].exp_state);
    end
    check("table_stalls",  int'(hif.StallCount),  2);
    check("table_flushes", int'(hif.FlushCount),  1);
    check("table_freezes", int'(hif.FreezeCount), 1);

    // Resync the model, then freeze with a pending branch: flush only after busy drops
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
    end
    check("frz_count3",   int'(hif.FreezeCount), 3);
    check("frz_noflush",  int'(hif.FlushCount),  0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    check("frz_then_flush", int'(hif.FlushCount), 1);
    check("frz_then_state", int'(hif.State),      2);

    // Timeout after exactly FREEZE_MAX consecutive busy cycles, sticky until reset
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      step();
    end
    check("to_after15", int'(hif.Timeout), 0);
    step();
    check("to_after16", int'(hif.Timeout), 1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      step();
    end
    check("to_sticky", int'(hif.Timeout), 1);
    do_reset();
    check("to_cleared", int'(hif.Timeout), 0);
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, (i != 15));
      step();
    end
    check("to_split_burst", int'(hif.Timeout), 0);

    // StallCount saturation with separate load-use hazards
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      step();
      idle(1'b1);
      step();
    end
    check("stall_sat", int'(hif.StallCount), 15);

    // Random traffic, biased toward register matches
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 3));
      step();
    end
    // Long freeze bursts inside random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 19) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
